// File: rtl/mram_macro_responder.sv
// Behavioural pin-level stand-in for the MRAM hard macro: register-array main and NVR
// stores, latency-accurate program/erase sequencing, and sticky protocol-violation flags.
module mram_macro_responder #(
   parameter int          DEPTH      = 1024,
   parameter int          NVR_DEPTH  = 16,
   parameter int          SECT_WORDS = 64,
   parameter int          PROG_LAT   = 40,
   parameter int          ERASE_LAT  = 80,
   parameter int          TPGS_CYC   = 800,
   parameter logic [77:0] ERASE_VAL  = 78'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mram_clk_en_i,
   input  logic        CEb_i,
   input  logic [15:0] A_i,
   input  logic [77:0] DIN_i,
   input  logic        RDEN_i,
   input  logic        WEb_i,
   input  logic        PROGEN_i,
   input  logic        PROG_i,
   input  logic        ERASE_i,
   input  logic        CHIP_i,
   input  logic        NVR_i,
   input  logic        TMEN_i,
   input  logic        AREF_i,
   input  logic [1:0]  err_inj_i,
   output logic        DONE_o,
   output logic [77:0] DOUT_o,
   output logic        EC_o,
   output logic        UE_o,
   output logic [3:0]  viol_o,
   input  logic        viol_clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = $clog2(NVR_DEPTH);
   localparam int SW = $clog2(SECT_WORDS);
   localparam int CW = $clog2(DEPTH + NVR_DEPTH + PROG_LAT + ERASE_LAT) + 1;
   localparam int TW = $clog2(TPGS_CYC + 1);
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_SWEEP, S_DONE} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_PROG, OP_ERASE} op_t;

   state_t         state_q, state_d;
   op_t            op_q, op_d;
   logic [AW-1:0]  a_q, a_d;
   logic [77:0]    din_q, din_d;
   logic           chip_q, chip_d, nvr_sel_q, nvr_sel_d, sect_q, sect_d;
   logic           tmen_q, tmen_d, oor_q, oor_d;
   logic [CW-1:0]  cnt_q, cnt_d, lat, sweep_len;
   logic [TW-1:0]  setup_q, setup_d;
   logic           progen_q, done_q, done_d, ec_q, ec_d, ue_q, ue_d;
   logic [77:0]    dout_q, dout_d, wdata;
   logic [3:0]     viol_q, viol_d, viol_set;
   logic           mem_we, nvr_we, setup_cond, progen_edge, rd_req, launch_oor;
   logic [AW-1:0]  mem_waddr;
   logic [NW-1:0]  nvr_waddr;

   logic [77:0] mem_q     [DEPTH];
   logic [77:0] nvr_mem_q [NVR_DEPTH];

   assign setup_cond  = !CEb_i && !WEb_i && (PROG_i || ERASE_i);
   assign progen_edge = PROGEN_i && !progen_q;
   assign rd_req      = mram_clk_en_i && !CEb_i && WEb_i && RDEN_i;
   assign launch_oor  = !NVR_i && ({1'b0, A_i} >= DEPTH_L);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      din_d     = din_q;
      chip_d    = chip_q;
      nvr_sel_d = nvr_sel_q;
      sect_d    = sect_q;
      tmen_d    = tmen_q;
      oor_d     = oor_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      ec_d      = ec_q;
      ue_d      = ue_q;
      viol_set  = '0;
      mem_we    = 1'b0;
      nvr_we    = 1'b0;
      mem_waddr = '0;
      nvr_waddr = '0;
      wdata     = ERASE_VAL;
      done_d    = (state_q == S_DONE) && PROGEN_i;
      lat       = tmen_q ? CW'(4) : ((op_q == OP_ERASE) ? CW'(ERASE_LAT) : CW'(PROG_LAT));
      sweep_len = chip_q ? (nvr_sel_q ? CW'(DEPTH + NVR_DEPTH) : CW'(DEPTH))
                         : (sect_q ? CW'(SECT_WORDS) : CW'(1));

      if (!setup_cond)                      setup_d = '0;
      else if (setup_q == TW'(TPGS_CYC))    setup_d = setup_q;
      else                                  setup_d = setup_q + TW'(1);

      // Reads are served only from IDLE; anything else is a protocol error.
      if (rd_req) begin
         if (state_q != S_IDLE) begin
            viol_set[2] = 1'b1;
         end else if (NVR_i) begin
            dout_d        = nvr_mem_q[A_i[NW-1:0]];
            {ec_d, ue_d}  = err_inj_i;
         end else if (launch_oor) begin
            dout_d      = '0;
            ec_d        = 1'b0;
            ue_d        = 1'b1;
            viol_set[3] = 1'b1;
         end else begin
            dout_d        = mem_q[A_i[AW-1:0]];
            {ec_d, ue_d}  = err_inj_i;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (progen_edge && !CEb_i && !WEb_i) begin
               state_d   = S_BUSY;
               cnt_d     = '0;
               a_d       = A_i[AW-1:0];
               din_d     = DIN_i;
               chip_d    = CHIP_i;
               nvr_sel_d = NVR_i;
               tmen_d    = TMEN_i;
               oor_d     = launch_oor;
               sect_d    = !CHIP_i && (A_i[SW-1:0] == '0) && DIN_i[0];
               if (setup_q < TW'(TPGS_CYC))        viol_set[0] = 1'b1;
               if ((PROG_i == ERASE_i) || AREF_i)  viol_set[1] = 1'b1;
               if (PROG_i == ERASE_i)              op_d = OP_NOP;
               else if (PROG_i)                    op_d = OP_PROG;
               else                                op_d = OP_ERASE;
               if (launch_oor && (PROG_i != ERASE_i) && !(ERASE_i && CHIP_i))
                  viol_set[3] = 1'b1;
            end
         end
         S_BUSY: begin
            if (cnt_q == lat - CW'(2)) begin
               cnt_d = '0;
               if (op_q == OP_ERASE) begin
                  state_d = S_SWEEP;
               end else begin
                  state_d = S_DONE;
                  if (op_q == OP_PROG && !oor_q) begin
                     wdata = din_q;
                     if (nvr_sel_q) begin
                        nvr_we    = 1'b1;
                        nvr_waddr = a_q[NW-1:0];
                     end else begin
                        mem_we    = 1'b1;
                        mem_waddr = a_q;
                     end
                  end
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SWEEP: begin
            // Chip erase walks the main array first, then the NVR words when selected.
            if (chip_q) begin
               if (cnt_q < CW'(DEPTH)) begin
                  mem_we    = 1'b1;
                  mem_waddr = cnt_q[AW-1:0];
               end else begin
                  nvr_we    = 1'b1;
                  nvr_waddr = cnt_q[NW-1:0];
               end
            end else if (!oor_q) begin
               if (nvr_sel_q) begin
                  nvr_we    = 1'b1;
                  nvr_waddr = a_q[NW-1:0] + cnt_q[NW-1:0];
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = a_q + cnt_q[AW-1:0];
               end
            end
            if (cnt_q == sweep_len - CW'(1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (!PROGEN_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      viol_d = (viol_clr_i ? 4'b0 : viol_q) | viol_set;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_NOP;
         a_q       <= '0;
         din_q     <= '0;
         chip_q    <= 1'b0;
         nvr_sel_q <= 1'b0;
         sect_q    <= 1'b0;
         tmen_q    <= 1'b0;
         oor_q     <= 1'b0;
         cnt_q     <= '0;
         setup_q   <= '0;
         progen_q  <= 1'b0;
         done_q    <= 1'b0;
         dout_q    <= '0;
         ec_q      <= 1'b0;
         ue_q      <= 1'b0;
         viol_q    <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         din_q     <= din_d;
         chip_q    <= chip_d;
         nvr_sel_q <= nvr_sel_d;
         sect_q    <= sect_d;
         tmen_q    <= tmen_d;
         oor_q     <= oor_d;
         cnt_q     <= cnt_d;
         setup_q   <= setup_d;
         progen_q  <= PROGEN_i;
         done_q    <= done_d;
         dout_q    <= dout_d;
         ec_q      <= ec_d;
         ue_q      <= ue_d;
         viol_q    <= viol_d;
      end
   end

   // NOTE: the stores model non-volatile cells, so they have no reset and keep contents across rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr]     <= wdata;
      if (nvr_we) nvr_mem_q[nvr_waddr] <= wdata;
   end

   assign DONE_o = done_q;
   assign DOUT_o = dout_q;
   assign EC_o   = ec_q;
   assign UE_o   = ue_q;
   assign viol_o = viol_q;

endmodule

// File: tb/tb_mram_macro_responder.sv
// Directed bench for mram_macro_responder: program, word/sector/chip erase, latencies,
// violation flags and read-side error reporting, checked against hand-computed values.
module tb_mram_macro_responder;

   localparam int DEPTH     = 1024;
   localparam int PROG_LAT  = 40;
   localparam int ERASE_LAT = 80;
   localparam int SECT      = 64;
   localparam int SETUP_OK  = 805;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mram_clk_en_i, CEb_i, RDEN_i, WEb_i, PROGEN_i, PROG_i, ERASE_i;
   logic        CHIP_i, NVR_i, TMEN_i, AREF_i, viol_clr_i;
   logic [15:0] A_i;
   logic [77:0] DIN_i;
   logic [1:0]  err_inj_i;
   logic        DONE_o, EC_o, UE_o;
   logic [77:0] DOUT_o;
   logic [3:0]  viol_o;

   int errors = 0;
   int checks = 0;

   localparam logic [77:0] D5   = 78'h3_1234_5678_9ABC_DEF0;
   localparam logic [77:0] D6   = 78'h2_AAAA_5555_0F0F_F0F0;
   localparam logic [77:0] D6B  = 78'h1_DEAD_BEEF_CAFE_F00D;
   localparam logic [77:0] D63  = 78'h0_0000_0000_0000_0063;
   localparam logic [77:0] D64  = 78'h0_0000_0000_0000_0064;
   localparam logic [77:0] D127 = 78'h3_FFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   mram_macro_responder dut (
      .clk(clk), .rst_n(rst_n), .mram_clk_en_i(mram_clk_en_i), .CEb_i(CEb_i), .A_i(A_i),
      .DIN_i(DIN_i), .RDEN_i(RDEN_i), .WEb_i(WEb_i), .PROGEN_i(PROGEN_i), .PROG_i(PROG_i),
      .ERASE_i(ERASE_i), .CHIP_i(CHIP_i), .NVR_i(NVR_i), .TMEN_i(TMEN_i), .AREF_i(AREF_i),
      .err_inj_i(err_inj_i), .DONE_o(DONE_o), .DOUT_o(DOUT_o), .EC_o(EC_o), .UE_o(UE_o),
      .viol_o(viol_o), .viol_clr_i(viol_clr_i)
   );

   task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Holds the op selects for `setup` cycles, then raises PROGEN on a falling edge.
   task automatic launch(input logic prog, input logic erase, input logic chip, input logic tmen,
                         input logic [15:0] addr, input logic [77:0] data, input int setup);
      @(negedge clk);
      CEb_i = 1'b0; WEb_i = 1'b0; PROG_i = prog; ERASE_i = erase; CHIP_i = chip;
      TMEN_i = tmen; A_i = addr; DIN_i = data; NVR_i = 1'b0;
      repeat (setup) @(negedge clk);
      PROGEN_i = 1'b1;
   endtask

   // n0 = falling edges already consumed since PROGEN rose; latency counts from the
   // rising clock edge that first samples PROGEN high.
   task automatic wait_done(input string tag, input int exp_lat, input int n0);
      int n = n0;
      while (DONE_o !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, 78'(n - 1), 78'(exp_lat));
      repeat (3) @(negedge clk);
      check({tag, "_hold"}, 78'(DONE_o), 78'(1));
      PROGEN_i = 1'b0;
      @(negedge clk);
      check({tag, "_fall"}, 78'(DONE_o), 78'(0));
      CEb_i = 1'b1; WEb_i = 1'b1; PROG_i = 1'b0; ERASE_i = 1'b0; CHIP_i = 1'b0; TMEN_i = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [1:0] inj,
                          output logic [77:0] d, output logic ec, output logic ue);
      CEb_i = 1'b0; WEb_i = 1'b1; RDEN_i = 1'b1; mram_clk_en_i = 1'b1;
      A_i = addr; NVR_i = 1'b0; err_inj_i = inj;
      @(negedge clk);
      d = DOUT_o; ec = EC_o; ue = UE_o;
      RDEN_i = 1'b0; CEb_i = 1'b1; err_inj_i = 2'b00;
   endtask

   task automatic clear_viol();
      viol_clr_i = 1'b1;
      @(negedge clk);
      viol_clr_i = 1'b0;
   endtask

   initial begin
      logic [77:0] d;
      logic        ec, ue;
      int          bad;

      rst_n = 1'b0; mram_clk_en_i = 1'b0; CEb_i = 1'b1; RDEN_i = 1'b0; WEb_i = 1'b1;
      PROGEN_i = 1'b0; PROG_i = 1'b0; ERASE_i = 1'b0; CHIP_i = 1'b0; NVR_i = 1'b0;
      TMEN_i = 1'b0; AREF_i = 1'b0; viol_clr_i = 1'b0; A_i = '0; DIN_i = '0; err_inj_i = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_done", 78'(DONE_o), 78'(0));
      check("rst_dout", DOUT_o, 78'(0));
      check("rst_ec",   78'(EC_o), 78'(0));
      check("rst_ue",   78'(UE_o), 78'(0));
      check("rst_viol", 78'(viol_o), 78'(0));

      // Program with setup met.
      launch(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, D5, SETUP_OK);
      wait_done("prog5", PROG_LAT, 0);
      do_read(16'd5, 2'b00, d, ec, ue);
      check("rd5_data", d, D5);
      check("rd5_ec",   78'(ec), 78'(0));
      check("rd5_ue",   78'(ue), 78'(0));
      check("prog5_viol", 78'(viol_o), 78'(0));

      // Short setup: flagged, write still lands.
      launch(1'b1, 1'b0, 1'b0, 1'b0, 16'd6, D6, 10);
      wait_done("prog6", PROG_LAT, 0);
      check("setup_viol", 78'(viol_o), 78'(4'b0001));
      do_read(16'd6, 2'b00, d, ec, ue);
      check("rd6_data", d, D6);
      clear_viol();
      check("viol_clr", 78'(viol_o), 78'(0));

      // Sector erase of 64..127, leaving 63 intact.
      launch(1'b1, 1'b0, 1'b0, 1'b0, 16'd63, D63, SETUP_OK);
      wait_done("prog63", PROG_LAT, 0);
      launch(1'b1, 1'b0, 1'b0, 1'b0, 16'd64, D64, SETUP_OK);
      wait_done("prog64", PROG_LAT, 0);
      launch(1'b1, 1'b0, 1'b0, 1'b0, 16'd127, D127, SETUP_OK);
      wait_done("prog127", PROG_LAT, 0);
      launch(1'b0, 1'b1, 1'b0, 1'b0, 16'd64, 78'h1, SETUP_OK);
      wait_done("sect", ERASE_LAT + SECT, 0);
      do_read(16'd63, 2'b00, d, ec, ue);
      check("sect_rd63", d, D63);
      do_read(16'd64, 2'b00, d, ec, ue);
      check("sect_rd64", d, 78'h0);
      do_read(16'd127, 2'b00, d, ec, ue);
      check("sect_rd127", d, 78'h0);
      check("sect_viol", 78'(viol_o), 78'(0));

      // Word erase (DIN[0]=0) touches only A=5.
      launch(1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 78'h0, SETUP_OK);
      wait_done("werase", ERASE_LAT + 1, 0);
      do_read(16'd5, 2'b00, d, ec, ue);
      check("werase_rd5", d, 78'h0);
      do_read(16'd6, 2'b00, d, ec, ue);
      check("werase_rd6", d, D6);

      // PROG&ERASE launch becomes a NOP; a read during BUSY is rejected.
      launch(1'b1, 1'b1, 1'b0, 1'b0, 16'd6, D6B, SETUP_OK);
      @(negedge clk);
      WEb_i = 1'b1; RDEN_i = 1'b1; mram_clk_en_i = 1'b1; A_i = 16'd5;
      @(negedge clk);
      RDEN_i = 1'b0;
      check("busy_rd_dout", DOUT_o, D6);
      check("nop_viol", 78'(viol_o), 78'(4'b0110));
      wait_done("nop", PROG_LAT, 2);
      do_read(16'd6, 2'b00, d, ec, ue);
      check("nop_mem", d, D6);

      // Out-of-range read in the same cycle as a clear: the new set survives.
      viol_clr_i = 1'b1;
      do_read(16'hFFFF, 2'b00, d, ec, ue);
      viol_clr_i = 1'b0;
      check("oor_dout", d, 78'h0);
      check("oor_ue",   78'(ue), 78'(1));
      check("oor_viol", 78'(viol_o), 78'(4'b1000));
      clear_viol();

      // Injected EC reported on one read only.
      do_read(16'd6, 2'b10, d, ec, ue);
      check("inj_ec", 78'(ec), 78'(1));
      check("inj_ue", 78'(ue), 78'(0));
      check("inj_data", d, D6);
      do_read(16'd6, 2'b00, d, ec, ue);
      check("inj_ec_next", 78'(ec), 78'(0));

      // Chip erase in test mode.
      launch(1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 78'h0, SETUP_OK);
      wait_done("chip", 4 + DEPTH, 0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         do_read(16'(i), 2'b00, d, ec, ue);
         if (d !== 78'h0) bad++;
      end
      check("chip_all_zero", 78'(bad), 78'(0));
      check("final_viol", 78'(viol_o), 78'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
